dac_ramp_ctrl: RTL and testbench
================================

DAC_RAMP_CTRL -- requirements
Module: dac_ramp_ctrl

Interface
REQ-001 SHALL have parameter DAC_DATA_WIDTH, default 14, DAC code width per channel.
REQ-002 SHALL have parameter AXIS_TDATA_WIDTH, default 32, packed two-channel DAC word width.
REQ-003 SHALL have parameter DATA_BITS, default 26, command payload width.
REQ-004 SHALL have parameter PERIOD_BITS, default 24, dwell counter width.
REQ-005 SHALL have one clock and an asynchronous, active-low reset, named as follows.
REQ-006 clk  input  1  system clock (FCLK_CLK0, 125 MHz).
REQ-007 rst_ni  input  1  asynchronous active-low reset.
REQ-008 cmd_i  input  4  command code (cmd_t).
REQ-009 data_i  input  DATA_BITS  command payload.
REQ-010 strobe_i  input  1  single-cycle command pulse (already edge-detected); cmd_i/data_i are valid only in this cycle.
REQ-011 dac_tdata_o  output  AXIS_TDATA_WIDTH  ch1 code in [13:0], ch2 code in [29:16], bits [15:14] and [31:30] zero.
REQ-012 dac_tvalid_o  output  1  DAC word valid.
REQ-013 status_o  output  32  {state[31:30], err[29], busy[28], done[27], ramp_ch[26], 12'b0, ramp_code[13:0]}.

Function
REQ-014 SHALL decode commands only in cycles where strobe_i=1; cmd_i is ignored otherwise.
REQ-015 CMD_SET_DAC (0010): data_i[25] selects channel (0=ch1, 1=ch2) and data_i[13:0] is the code; dac_tdata_o SHALL update on the clock edge following the strobe (1-cycle latency).
REQ-016 CMD_RAMP_START (0011), CMD_RAMP_STOP (0100), CMD_RAMP_STEP (0101) SHALL load data_i[13:0] into the start, stop and step registers; CMD_RAMP_PERIOD (0110) SHALL load data_i[23:0] into the period register.
REQ-017 CMD_RAMP_RUN (0111): data_i[0] selects ramp_ch and data_i[1] selects continuous mode; ramp_code SHALL load start and the FSM SHALL enter S_DWELL.
REQ-018 CMD_RAMP_ABORT (1000) SHALL return the FSM to S_IDLE within 1 cycle and hold the last ramp code on the DAC.
REQ-019 CMD_CLR_ERR (1001) SHALL clear err; any other code SHALL be ignored with no state change.
REQ-020 FSM states: S_IDLE=0, S_DWELL=1, S_STEP=2, S_DONE=3.
REQ-021 S_DWELL SHALL count period cycles, with period=0 treated as 1, then move to S_STEP.
REQ-022 S_STEP SHALL last 1 cycle and move ramp_code toward stop by step: up if stop>=start, down otherwise.
REQ-023 The ramp code SHALL saturate exactly at stop with no overshoot and no 14-bit wrap; the arithmetic SHALL use a 15-bit intermediate.
REQ-024 On reaching stop: in continuous mode, the next S_STEP SHALL reload start (sawtooth); in single mode, the FSM SHALL enter S_DONE.
REQ-025 S_DONE SHALL assert done for 1 cycle, then move to S_IDLE.
REQ-026 The ramped channel of dac_tdata_o SHALL follow ramp_code while busy=1.
REQ-027 busy SHALL be 1 in S_DWELL and S_STEP.
REQ-028 RUN with step=0 SHALL be rejected: err set, FSM stays in S_IDLE.
REQ-029 While busy=1, the following SHALL set err and be otherwise ignored: configuration commands, RUN, and SET_DAC to the ramped channel.
REQ-030 While busy=1, SET_DAC to the other channel SHALL be accepted.
REQ-031 A strobe in the same cycle as the dwell expiry SHALL be processed before the step, so ABORT wins and the step is not taken.
REQ-032 start=stop in single mode SHALL output start for one dwell, then enter S_DONE.

Reset
REQ-033 While rst_ni=0: dac_tdata_o=0, dac_tvalid_o=0, status_o=0, all registers 0, FSM in S_IDLE.
REQ-034 dac_tvalid_o SHALL rise on the first clock edge after reset release and stay 1.
REQ-035 Reset asserted mid-ramp SHALL immediately zero the outputs, with no completion or done pulse.

Structure
REQ-036 cmd_t, the FSM state enum and the status bit positions SHALL live in shared package pdh_pkg, which the PDH core also imports.
REQ-037 The dwell counter SHALL be a sub-module, dwell_timer (load/enable/expire).

Verification
REQ-038 SET_DAC ch2 code 0x1ABC -> dac_tdata_o=0x1ABC0000 one cycle after the strobe.
REQ-039 start=100, stop=130, step=10, period=4, single RUN ch1 -> ch1 sequence 100,110,120,130, each held 5 cycles (4 dwell + 1 step), then a one-cycle done pulse.
REQ-040 start=20, stop=0, step=7 -> sequence 20,13,6,0 (saturating); continuous mode -> returns to 20 after 0.
REQ-041 Ramp running on ch1 -> SET_DAC ch1 sets err with ch1 unchanged; SET_DAC ch2 0x0005 is applied.
REQ-042 RUN with step=0 -> err=1, busy=0; then CLR_ERR -> err=0.
REQ-043 rst_ni low mid-ramp -> all outputs 0 asynchronously; after release, tvalid=1 on the next clock edge and state=S_IDLE.

Source files
------------

// File: rtl/pdh_pkg.sv
// Shared definitions for the PDH control plane: command codes, ramp FSM states, status word layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pdh_pkg;

    // Command codes carried on cmd_i alongside a strobe.
    typedef enum logic [3:0] {
        CMD_NOP          = 4'h0,
        CMD_SET_DAC      = 4'h2,
        CMD_RAMP_START   = 4'h3,
        CMD_RAMP_STOP    = 4'h4,
        CMD_RAMP_STEP    = 4'h5,
        CMD_RAMP_PERIOD  = 4'h6,
        CMD_RAMP_RUN     = 4'h7,
        CMD_RAMP_ABORT   = 4'h8,
        CMD_CLR_ERR      = 4'h9
    } cmd_t;

    // Ramp sequencer states; the encoding is visible in the status word.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DWELL = 2'd1,
        S_STEP  = 2'd2,
        S_DONE  = 2'd3
    } ramp_state_t;

    // Status word bit positions.
    localparam int ST_STATE_LSB = 30;
    localparam int ST_ERR       = 29;
    localparam int ST_BUSY      = 28;
    localparam int ST_DONE      = 27;
    localparam int ST_RAMP_CH   = 26;

endpackage

// File: rtl/dwell_timer.sv
// Dwell timer: counts a programmable number of enabled cycles and flags the last one.
// Latency: expire is high during the period-th enabled cycle after load (period 0 acts as 1).
// Backpressure: none; counting pauses while enable is low, load always wins.
//
// Ports:
//   clk, rst_ni  clock and asynchronous active-low reset
//   load         restart the count from period
//   enable       advance the count this cycle
//   period       dwell length in cycles
//   expire       high in the final cycle of the dwell (only while enable is high)
module dwell_timer #(
    parameter int PERIOD_BITS = 24
) (
    input  logic                   clk,
    input  logic                   rst_ni,
    input  logic                   load,
    input  logic                   enable,
    input  logic [PERIOD_BITS-1:0] period,
    output logic                   expire
);

    localparam logic [PERIOD_BITS-1:0] ONE = PERIOD_BITS'(1);

    logic [PERIOD_BITS-1:0] cnt;

    // The counter parks at 1 so that expire stays aligned with the last
    // dwell cycle until the owner reloads it.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= (period == '0) ? ONE : period;
        end else if (enable && (cnt > ONE)) begin
            cnt <= cnt - ONE;
        end
    end

    assign expire = enable && (cnt == ONE);

endmodule

// File: rtl/dac_ramp_ctrl.sv
// Two-channel DAC controller: direct code writes plus a saturating single/sawtooth ramp on one channel.
// Latency: accepted commands take effect on the clock edge after the strobe; each ramp code is held period+1 cycles.
// Backpressure: none; commands are never stalled, those that conflict with a running ramp are dropped and flag err.
//
// Ports:
//   clk, rst_ni    clock and asynchronous active-low reset
//   cmd_i, data_i  command code and payload, valid only while strobe_i is high
//   strobe_i       single-cycle command pulse
//   dac_tdata_o    {2'b0, ch2[13:0], 2'b0, ch1[13:0]}
//   dac_tvalid_o   high from the first edge after reset release
//   status_o       {state, err, busy, done, ramp_ch, 12'b0, ramp_code}
module dac_ramp_ctrl
    import pdh_pkg::*;
#(
    parameter int DAC_DATA_WIDTH   = 14,
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int DATA_BITS        = 26,
    parameter int PERIOD_BITS      = 24
) (
    input  logic                        clk,
    input  logic                        rst_ni,
    input  logic [3:0]                  cmd_i,
    input  logic [DATA_BITS-1:0]        data_i,
    input  logic                        strobe_i,
    output logic [AXIS_TDATA_WIDTH-1:0] dac_tdata_o,
    output logic                        dac_tvalid_o,
    output logic [31:0]                 status_o
);

    localparam int DW   = DAC_DATA_WIDTH;
    localparam int HALF = AXIS_TDATA_WIDTH / 2;

    cmd_t                   cmd;
    ramp_state_t            state_q;
    logic [DW-1:0]          ch1_q, ch2_q;
    logic [DW-1:0]          start_q, stop_q, step_q;
    logic [PERIOD_BITS-1:0] period_q;
    logic [DW-1:0]          ramp_code_q;
    logic                   ramp_ch_q, cont_q, err_q, done_q, tvalid_q;

    logic                   busy, is_abort, sel_ch, run_ok, timer_load, dwell_exp;
    logic [DW:0]            sum, diff;
    logic [DW-1:0]          step_val;
    logic                   unused_data;

    assign cmd         = cmd_t'(cmd_i);
    assign busy        = (state_q == S_DWELL) || (state_q == S_STEP);
    assign is_abort    = strobe_i && (cmd == CMD_RAMP_ABORT);
    assign sel_ch      = data_i[DATA_BITS-1];
    assign run_ok      = strobe_i && (cmd == CMD_RAMP_RUN) && !busy && (step_q != '0);
    // Reload the dwell on a fresh run and on every step that is not aborted.
    assign timer_load  = run_ok || ((state_q == S_STEP) && !is_abort);
    assign unused_data = ^data_i;

    dwell_timer #(
        .PERIOD_BITS (PERIOD_BITS)
    ) u_dwell_timer (
        .clk    (clk),
        .rst_ni (rst_ni),
        .load   (timer_load),
        .enable (state_q == S_DWELL),
        .period (period_q),
        .expire (dwell_exp)
    );

    // Next ramp code. One extra bit catches both carry-out and borrow so the
    // code clamps exactly at stop instead of wrapping. Sitting on stop means
    // a sawtooth restart.
    always_comb begin
        sum      = {1'b0, ramp_code_q} + {1'b0, step_q};
        diff     = {1'b0, ramp_code_q} - {1'b0, step_q};
        step_val = ramp_code_q;
        if (ramp_code_q == stop_q) begin
            step_val = start_q;
        end else if (stop_q >= start_q) begin
            step_val = (sum >= {1'b0, stop_q}) ? stop_q : sum[DW-1:0];
        end else begin
            step_val = (diff[DW] || (diff[DW-1:0] <= stop_q)) ? stop_q : diff[DW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            ch1_q       <= '0;
            ch2_q       <= '0;
            start_q     <= '0;
            stop_q      <= '0;
            step_q      <= '0;
            period_q    <= '0;
            ramp_code_q <= '0;
            ramp_ch_q   <= 1'b0;
            cont_q      <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            tvalid_q    <= 1'b0;
        end else begin
            tvalid_q <= 1'b1;
            done_q   <= 1'b0;

            // Sequencer progress. An abort in the same cycle suppresses it
            // entirely, so a coincident dwell expiry never steps the code.
            if (!is_abort) begin
                case (state_q)
                    S_DWELL: begin
                        if (dwell_exp) begin
                            if ((ramp_code_q == stop_q) && !cont_q) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= S_STEP;
                            end
                        end
                    end
                    S_STEP: begin
                        ramp_code_q <= step_val;
                        if (ramp_ch_q) ch2_q <= step_val;
                        else           ch1_q <= step_val;
                        state_q <= S_DWELL;
                    end
                    S_DONE:  state_q <= S_IDLE;
                    default: ;
                endcase
            end

            // Command decode; later assignments override the sequencer above.
            if (strobe_i) begin
                case (cmd)
                    CMD_SET_DAC: begin
                        if (busy && (sel_ch == ramp_ch_q)) err_q <= 1'b1;
                        else if (sel_ch)                   ch2_q <= data_i[DW-1:0];
                        else                               ch1_q <= data_i[DW-1:0];
                    end
                    CMD_RAMP_START: begin
                        if (busy) err_q <= 1'b1;
                        else      start_q <= data_i[DW-1:0];
                    end
                    CMD_RAMP_STOP: begin
                        if (busy) err_q <= 1'b1;
                        else      stop_q <= data_i[DW-1:0];
                    end
                    CMD_RAMP_STEP: begin
                        if (busy) err_q <= 1'b1;
                        else      step_q <= data_i[DW-1:0];
                    end
                    CMD_RAMP_PERIOD: begin
                        if (busy) err_q <= 1'b1;
                        else      period_q <= data_i[PERIOD_BITS-1:0];
                    end
                    CMD_RAMP_RUN: begin
                        if (!run_ok) begin
                            err_q <= 1'b1;
                        end else begin
                            ramp_ch_q   <= data_i[0];
                            cont_q      <= data_i[1];
                            ramp_code_q <= start_q;
                            if (data_i[0]) ch2_q <= start_q;
                            else           ch1_q <= start_q;
                            state_q     <= S_DWELL;
                        end
                    end
                    CMD_RAMP_ABORT: state_q <= S_IDLE;
                    CMD_CLR_ERR:    err_q   <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

    assign dac_tdata_o  = {{(HALF-DW){1'b0}}, ch2_q, {(HALF-DW){1'b0}}, ch1_q};
    assign dac_tvalid_o = tvalid_q;

    always_comb begin
        status_o                     = '0;
        status_o[ST_STATE_LSB +: 2]  = state_q;
        status_o[ST_ERR]             = err_q;
        status_o[ST_BUSY]            = busy;
        status_o[ST_DONE]            = done_q;
        status_o[ST_RAMP_CH]         = ramp_ch_q;
        status_o[DW-1:0]             = ramp_code_q;
    end

endmodule

// File: tb/tb_dac_ramp_ctrl.sv
// Bench for dac_ramp_ctrl: directed scenarios plus randomized ramps against a list-based ramp model.
// Latency: samples on the falling edge, one cycle after each strobe.
// Backpressure: n/a.
module tb_dac_ramp_ctrl;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [3:0]  cmd;
    logic [25:0] data;
    logic        strobe;
    logic [31:0] tdata;
    logic        tvalid;
    logic [31:0] status;

    int checks   = 0;
    int failures = 0;

    // Model of the externally visible state.
    int m_ch1, m_ch2, m_code, m_err, m_rch;
    int m_start, m_stop, m_step, m_period;

    always #5 clk = ~clk;

    dac_ramp_ctrl dut (
        .clk          (clk),
        .rst_ni       (rst_ni),
        .cmd_i        (cmd),
        .data_i       (data),
        .strobe_i     (strobe),
        .dac_tdata_o  (tdata),
        .dac_tvalid_o (tvalid),
        .status_o     (status)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_status(input int st, input int bz, input int dn, input int code);
        logic [31:0] s;
        s = 32'(st) * 32'h4000_0000 + 32'(m_err) * 32'h2000_0000 + 32'(bz) * 32'h1000_0000
          + 32'(dn) * 32'h0800_0000 + 32'(m_rch) * 32'h0400_0000 + 32'(code);
        return s;
    endfunction

    function automatic logic [31:0] exp_tdata();
        return 32'(m_ch2) * 32'h1_0000 + 32'(m_ch1);
    endfunction

    // Called on a falling edge; the strobe is captured by the next rising edge
    // and the call returns on the following falling edge.
    task automatic send(input logic [3:0] c, input logic [25:0] d);
        cmd    = c;
        data   = d;
        strobe = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
        cmd    = 4'h0;
        data   = '0;
    endtask

    task automatic cfg(input int s, input int p, input int st, input int per);
        send(4'h3, 26'(s));   m_start  = s;
        send(4'h4, 26'(p));   m_stop   = p;
        send(4'h5, 26'(st));  m_step   = st;
        send(4'h6, 26'(per)); m_period = per;
    endtask

    // Run a ramp and check every cycle against the code list the settings imply.
    task automatic run_ramp(input int ch, input int cont, input string tag);
        int codes[$];
        int c, n, p, h, tot, cd, st, bz, dn;
        c = m_start;
        codes.push_back(c);
        while (c != m_stop) begin
            if (m_stop >= m_start) c = (c + m_step >= m_stop) ? m_stop : c + m_step;
            else                   c = (c - m_step <= m_stop) ? m_stop : c - m_step;
            codes.push_back(c);
        end
        n   = codes.size();
        p   = (m_period == 0) ? 1 : m_period;
        h   = p + 1;
        tot = cont ? n * h + 2 : (n - 1) * h + p + 2;
        send(4'h7, 26'(cont * 2 + ch));
        m_rch = ch;
        for (int t = 0; t < tot; t++) begin
            bz = 1; dn = 0;
            if (cont != 0) begin
                cd = codes[(t / h) % n];
                st = (t % h == h - 1) ? 2 : 1;
            end else if (t < (n - 1) * h) begin
                cd = codes[t / h];
                st = (t % h == h - 1) ? 2 : 1;
            end else if (t < (n - 1) * h + p) begin
                cd = codes[n - 1]; st = 1;
            end else if (t == (n - 1) * h + p) begin
                cd = codes[n - 1]; st = 3; bz = 0; dn = 1;
            end else begin
                cd = codes[n - 1]; st = 0; bz = 0;
            end
            m_code = cd;
            if (ch != 0) m_ch2 = cd; else m_ch1 = cd;
            chk({tag, "_dat"}, tdata, exp_tdata());
            chk({tag, "_sts"}, status, exp_status(st, bz, dn, cd));
            @(negedge clk);
        end
        if (cont != 0) begin
            // Abort freezes whatever code is on the DAC in the abort cycle.
            cd = codes[(tot / h) % n];
            send(4'h8, 26'd0);
            m_code = cd;
            if (ch != 0) m_ch2 = cd; else m_ch1 = cd;
            chk({tag, "_abort_dat"}, tdata, exp_tdata());
            chk({tag, "_abort_sts"}, status, exp_status(0, 0, 0, cd));
        end
    endtask

    initial begin
        int s, p, d, stp, per, ch, cont;
        rst_ni = 1'b0;
        cmd    = 4'h0;
        data   = '0;
        strobe = 1'b0;
        m_ch1 = 0; m_ch2 = 0; m_code = 0; m_err = 0; m_rch = 0;
        m_start = 0; m_stop = 0; m_step = 0; m_period = 0;

        // Reset values and tvalid rising on the first edge after release.
        repeat (2) @(negedge clk);
        chk("rst_tdata", tdata, 32'h0);
        chk("rst_tvalid", {31'b0, tvalid}, 32'h0);
        chk("rst_status", status, 32'h0);
        rst_ni = 1'b1;
        @(negedge clk);
        chk("rel_tvalid", {31'b0, tvalid}, 32'h1);
        chk("rel_status", status, 32'h0);

        // Direct DAC writes.
        send(4'h2, 26'h200_1ABC);
        m_ch2 = 'h1ABC;
        chk("set_ch2", tdata, 32'h1ABC_0000);
        send(4'h2, 26'h000_0123);
        m_ch1 = 'h0123;
        chk("set_ch1", tdata, 32'h1ABC_0123);
        send(4'hF, 26'h000_0777);
        chk("bad_cmd_dat", tdata, 32'h1ABC_0123);
        chk("bad_cmd_sts", status, 32'h0);

        // Single up ramp 100..130, down ramp with saturation, sawtooth on ch2.
        cfg(100, 130, 10, 4);
        run_ramp(0, 0, "up_single");
        cfg(20, 0, 7, 2);
        run_ramp(0, 0, "down_single");
        run_ramp(1, 1, "down_cont");
        // start == stop with period 0: one single-cycle dwell, then done.
        cfg(50, 50, 3, 0);
        run_ramp(0, 0, "flat");

        // Abort arriving in the dwell-expiry cycle wins over the step.
        cfg(1000, 2000, 100, 3);
        send(4'h7, 26'd0);
        m_rch = 0; m_code = 1000; m_ch1 = 1000;
        chk("abx_run", status, exp_status(1, 1, 0, 1000));
        @(negedge clk);
        @(negedge clk);
        send(4'h8, 26'd0);
        chk("abx_sts", status, exp_status(0, 0, 0, 1000));
        chk("abx_dat", tdata, exp_tdata());
        repeat (3) @(negedge clk);
        chk("abx_hold", status, exp_status(0, 0, 0, 1000));

        // Conflicting commands while a ramp is running on ch1.
        cfg(500, 600, 1, 40);
        send(4'h7, 26'd2);
        m_rch = 0; m_code = 500; m_ch1 = 500;
        chk("busy_run", status, exp_status(1, 1, 0, 500));
        send(4'h2, 26'h000_0777);
        m_err = 1;
        chk("busy_set_own_dat", tdata, exp_tdata());
        chk("busy_set_own_sts", status, exp_status(1, 1, 0, 500));
        send(4'h2, 26'h200_0005);
        m_ch2 = 5;
        chk("busy_set_other", tdata, exp_tdata());
        send(4'h9, 26'd0);
        m_err = 0;
        chk("busy_clr", status, exp_status(1, 1, 0, 500));
        send(4'h3, 26'd9000);
        m_err = 1;
        chk("busy_cfg", status, exp_status(1, 1, 0, 500));
        send(4'h9, 26'd0);
        m_err = 0;
        send(4'h7, 26'd1);
        m_err = 1;
        chk("busy_rerun", status, exp_status(1, 1, 0, 500));
        send(4'h8, 26'd0);
        chk("busy_abort", status, exp_status(0, 0, 0, 500));
        send(4'h9, 26'd0);
        m_err = 0;
        send(4'h7, 26'd0);
        chk("start_kept", status, exp_status(1, 1, 0, 500));
        send(4'h8, 26'd0);
        chk("start_kept_abort", status, exp_status(0, 0, 0, 500));

        // RUN with a zero step is rejected.
        send(4'h5, 26'd0);
        m_step = 0;
        send(4'h7, 26'd0);
        m_err = 1;
        chk("step0_run", status, exp_status(0, 0, 0, m_code));
        @(negedge clk);
        chk("step0_idle", status, exp_status(0, 0, 0, m_code));
        send(4'h9, 26'd0);
        m_err = 0;
        chk("step0_clr", status, exp_status(0, 0, 0, m_code));

        // Randomized ramps.
        for (int i = 0; i < 6; i++) begin
            s    = int'($urandom_range(16383, 0));
            p    = int'($urandom_range(16383, 0));
            d    = (s > p) ? s - p : p - s;
            stp  = int'($urandom_range(d / 3 + 1, d / 8 + 1));
            per  = int'($urandom_range(3, 0));
            ch   = int'($urandom_range(1, 0));
            cont = int'($urandom_range(1, 0));
            cfg(s, p, stp, per);
            run_ramp(ch, cont, "rnd");
        end

        // Reset mid-ramp clears outputs at once, with no done pulse.
        cfg(10, 90, 10, 2);
        send(4'h7, 26'd0);
        repeat (3) @(negedge clk);
        #2 rst_ni = 1'b0;
        #1;
        chk("mid_rst_tdata", tdata, 32'h0);
        chk("mid_rst_tvalid", {31'b0, tvalid}, 32'h0);
        chk("mid_rst_status", status, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("mid_rst_hold", status, 32'h0);
        rst_ni = 1'b1;
        m_ch1 = 0; m_ch2 = 0; m_code = 0; m_err = 0; m_rch = 0;
        m_start = 0; m_stop = 0; m_step = 0; m_period = 0;
        @(negedge clk);
        chk("post_rst_tvalid", {31'b0, tvalid}, 32'h1);
        chk("post_rst_status", status, exp_status(0, 0, 0, 0));
        chk("post_rst_tdata", tdata, exp_tdata());
        // Step register was cleared by reset, so RUN must be refused.
        send(4'h7, 26'd0);
        m_err = 1;
        chk("post_rst_run", status, exp_status(0, 0, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
